// File: rtl/txrx_slot_scheduler.sv
// TDMA slot scheduler for the half-duplex VLC link.
// Splits time into NUM_SLOTS slots per frame. After a guard interval at the
// start of each slot it pulses the tx loop in the node's own slot and the rx
// loop in the other slots. It then watches the loop's active handshake for a
// start timeout and checks for a loop still busy when the slot ends.
module txrx_slot_scheduler #(
  parameter int NUM_SLOTS   = 4,
  parameter int CNT_W       = 32,
  parameter int GUARD_CNT   = 2000,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_enable,
  input  logic [7:0]                   i_node_id,
  input  logic [CNT_W-1:0]             i_slot_len,
  input  logic                         i_rx_en,
  input  logic                         i_tx_active,
  input  logic                         i_rx_active,
  input  logic                         i_clr_err,
  output logic                         o_tx_start,
  output logic                         o_rx_start,
  output logic [$clog2(NUM_SLOTS)-1:0] o_slot_idx,
  output logic                         o_slot_strobe,
  output logic                         o_busy,
  output logic                         o_start_err,
  output logic                         o_overrun
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  // A slot must be long enough to hold the guard, the pulse, the whole ack
  // window and one cycle of margin before it wraps.
  localparam logic [CNT_W-1:0] LEN_MIN    = CNT_W'(GUARD_CNT + ACK_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CNT - 1);
  localparam logic [ACK_W-1:0] ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GUARD = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic [IDX_W-1:0] r_idx;
  logic [ACK_W-1:0] r_ack_cnt;
  logic             r_sel_tx;
  logic             r_tx_start;
  logic             r_rx_start;
  logic             r_strobe;
  logic             r_start_err;
  logic             r_overrun;

  logic w_run;
  logic w_wrap;
  logic w_own;
  logic w_sel_active;
  logic w_err_evt;
  logic w_ovr_evt;
  logic w_unused;

  assign w_run        = (r_state != S_IDLE) && i_enable;
  assign w_wrap       = (r_cnt == r_len - CNT_W'(1));
  assign w_own        = (r_idx == i_node_id[IDX_W-1:0]);
  assign w_sel_active = r_sel_tx ? i_tx_active : i_rx_active;
  // r_ack_cnt holds the number of cycles since the pulse; the last cycle of
  // the window without an ack raises the error.
  assign w_err_evt    = w_run && (r_state == S_WAIT) && !w_sel_active &&
                        (r_ack_cnt >= ACK_LAST);
  assign w_ovr_evt    = w_run && w_wrap && (i_tx_active || i_rx_active);
  // Only the low node-id bits select a slot.
  assign w_unused     = &{1'b0, i_node_id[7:IDX_W]};

  // Slot timing, state sequencing and registered start/strobe pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_ack_cnt  <= '0;
      r_sel_tx   <= 1'b0;
      r_tx_start <= 1'b0;
      r_rx_start <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_rx_start <= 1'b0;
      r_strobe   <= 1'b0;
      if (r_state == S_IDLE) begin
        if (i_enable) begin
          r_len    <= (i_slot_len < LEN_MIN) ? LEN_MIN : i_slot_len;
          r_cnt    <= '0;
          r_idx    <= '0;
          r_strobe <= 1'b1;
          r_state  <= S_GUARD;
        end
      end else if (!i_enable) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_idx   <= '0;
      end else if (w_wrap) begin
        r_cnt    <= '0;
        r_idx    <= r_idx + IDX_W'(1);
        r_strobe <= 1'b1;
        r_state  <= S_GUARD;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        case (r_state)
          S_GUARD: begin
            // Node id and rx enable are sampled on entry to START.
            if (r_cnt == GUARD_LAST) begin
              r_state    <= S_START;
              r_sel_tx   <= w_own;
              r_tx_start <= w_own;
              r_rx_start <= !w_own && i_rx_en;
            end
          end
          S_START: begin
            r_ack_cnt <= ACK_W'(1);
            r_state   <= (r_tx_start || r_rx_start) ? S_WAIT : S_RUN;
          end
          S_WAIT: begin
            if (w_sel_active || (r_ack_cnt >= ACK_LAST)) r_state <= S_RUN;
            else r_ack_cnt <= r_ack_cnt + ACK_W'(1);
          end
          S_RUN: r_state <= S_RUN;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Sticky error flags; a set event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_start_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_err_evt)      r_start_err <= 1'b1;
      else if (i_clr_err) r_start_err <= 1'b0;
      if (w_ovr_evt)      r_overrun   <= 1'b1;
      else if (i_clr_err) r_overrun   <= 1'b0;
    end
  end

  assign o_tx_start    = r_tx_start;
  assign o_rx_start    = r_rx_start;
  assign o_slot_idx    = r_idx;
  assign o_slot_strobe = r_strobe;
  assign o_busy        = (r_state != S_IDLE);
  assign o_start_err   = r_start_err;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_txrx_slot_scheduler.sv
// Bench for txrx_slot_scheduler: table-driven timing rows, directed corner
// sequences, and a randomized phase checked against a slot-arithmetic model.
module tb_txrx_slot_scheduler;
  localparam int NS = 4, CW = 32, G = 4, AT = 8, LMIN = G + AT + 2;

  logic          clk = 1'b0, reset_n = 1'b0, i_enable = 1'b0, i_rx_en = 1'b0;
  logic          i_tx_active = 1'b0, i_rx_active = 1'b0, i_clr_err = 1'b0;
  logic [7:0]    i_node_id = '0;
  logic [CW-1:0] i_slot_len = '0;
  logic          o_tx_start, o_rx_start, o_slot_strobe, o_busy, o_start_err, o_overrun;
  logic [1:0]    o_slot_idx;

  always #5 clk = ~clk;

  txrx_slot_scheduler #(.NUM_SLOTS(NS), .CNT_W(CW), .GUARD_CNT(G), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_node_id(i_node_id),
    .i_slot_len(i_slot_len), .i_rx_en(i_rx_en), .i_tx_active(i_tx_active),
    .i_rx_active(i_rx_active), .i_clr_err(i_clr_err), .o_tx_start(o_tx_start),
    .o_rx_start(o_rx_start), .o_slot_idx(o_slot_idx), .o_slot_strobe(o_slot_strobe),
    .o_busy(o_busy), .o_start_err(o_start_err), .o_overrun(o_overrun));

  int total = 0, bad = 0, rel = 0;
  bit auto_ack = 0;
  int tx_cd = 0, rx_cd = 0, tx_hold = 0, rx_hold = 0;

  // Reference model: position in the run is a plain cycle count m_t; slot
  // counter and index come from division by the effective slot length.
  bit m_run, m_pend, m_ptx, m_tx, m_rx, m_err, m_ov;
  int m_t, m_len, m_pt;

  function automatic void model_edge();
    bit set_e = 0, set_o = 0;
    int idx;
    m_tx = 0; m_rx = 0;
    if (!reset_n) begin
      m_run = 0; m_pend = 0; m_err = 0; m_ov = 0; m_t = 0; m_len = 0;
      return;
    end
    if (m_run && i_enable) begin
      if ((m_t % m_len == m_len - 1) && (i_tx_active || i_rx_active)) set_o = 1;
      if (m_pend && m_t > m_pt) begin
        if (m_ptx ? i_tx_active : i_rx_active) m_pend = 0;
        else if (m_t - m_pt == AT - 1) begin set_e = 1; m_pend = 0; end
      end
      m_t++;
      if (m_t % m_len == G) begin
        idx  = (m_t / m_len) % NS;
        m_tx = (idx == int'(i_node_id) % NS);
        m_rx = !m_tx && i_rx_en;
        if (m_tx || m_rx) begin m_pend = 1; m_pt = m_t; m_ptx = m_tx; end
      end
    end else if (m_run) begin
      m_run = 0; m_pend = 0;
    end else if (i_enable) begin
      m_run = 1; m_t = 0; m_pend = 0;
      m_len = (int'(i_slot_len) < LMIN) ? LMIN : int'(i_slot_len);
    end
    if (set_e) m_err = 1; else if (i_clr_err) m_err = 0;
    if (set_o) m_ov = 1;  else if (i_clr_err) m_ov = 0;
  endfunction

  function automatic logic [7:0] mexp();
    int idx = 0;
    bit sb = 0;
    if (m_run) begin
      idx = (m_t / m_len) % NS;
      sb  = (m_t % m_len == 0);
    end
    return {m_tx, m_rx, 2'(idx), sb, m_run, m_err, m_ov};
  endfunction

  function automatic logic [7:0] dutv();
    return {o_tx_start, o_rx_start, o_slot_idx, o_slot_strobe, o_busy, o_start_err, o_overrun};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (rel=%0d t=%0t)", nm, act, exp, rel, $time);
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs are then
  // sampled 1 time unit after it. Optional loop emulation acks 2 cycles
  // after each pulse and stays busy for 4 cycles.
  task automatic step();
    model_edge();
    @(posedge clk); #1;
    rel++;
    if (auto_ack) begin
      if (tx_hold > 0) tx_hold--;
      if (rx_hold > 0) rx_hold--;
      if (tx_cd > 0) begin tx_cd--; if (tx_cd == 0) tx_hold = 4; end
      if (rx_cd > 0) begin rx_cd--; if (rx_cd == 0) rx_hold = 4; end
      if (o_tx_start) tx_cd = 2;
      if (o_rx_start) rx_cd = 2;
      i_tx_active = (tx_hold > 0);
      i_rx_active = (rx_hold > 0);
    end
  endtask

  task automatic run_to(input int k);
    while (rel < k) step();
  endtask

  task automatic do_reset();
    reset_n = 0; i_enable = 0; i_tx_active = 0; i_rx_active = 0; i_clr_err = 0;
    auto_ack = 0; tx_cd = 0; rx_cd = 0; tx_hold = 0; rx_hold = 0;
    step();
    reset_n = 1;
  endtask

  task automatic start_run(input int slen, input int node, input bit rxen);
    i_slot_len = CW'(slen); i_node_id = 8'(node); i_rx_en = rxen;
    i_enable = 1; rel = 0;
  endtask

  typedef struct {
    int slen; int node; bit rxen; int per; int tx_at; int rx_at; int rx_n;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int first_tx, first_rx, ntx, nrx, nsb, badgap, last_sb;
    tbl[0] = '{20, 2, 1'b1, 20, 45,  5, 3};
    tbl[1] = '{ 5, 2, 1'b1, 14, 33,  5, 3};
    tbl[2] = '{20, 0, 1'b0, 20,  5, -1, 0};
    tbl[3] = '{16, 5, 1'b1, 16, 21,  5, 3};
    tbl[4] = '{14, 3, 1'b1, 14, 47,  5, 3};
    tbl[5] = '{ 0, 1, 1'b1, 14, 19,  5, 3};

    do_reset();
    chk("reset_state", dutv(), 8'h00);

    // Pulse placement and slot period over one frame per table row.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      start_run(tbl[r].slen, tbl[r].node, tbl[r].rxen);
      auto_ack = 1;
      first_tx = -1; first_rx = -1; ntx = 0; nrx = 0; nsb = 0; badgap = 0; last_sb = -1;
      for (int k = 0; k < 4 * tbl[r].per; k++) begin
        step();
        if (o_tx_start) begin ntx++; if (first_tx < 0) first_tx = rel; end
        if (o_rx_start) begin nrx++; if (first_rx < 0) first_rx = rel; end
        if (o_slot_strobe) begin
          if (last_sb < 0 && rel != 1) badgap++;
          if (last_sb >= 0 && rel - last_sb != tbl[r].per) badgap++;
          last_sb = rel; nsb++;
        end
      end
      chk($sformatf("row%0d_tx_at", r), first_tx, tbl[r].tx_at);
      chk($sformatf("row%0d_rx_at", r), first_rx, tbl[r].rx_at);
      chk($sformatf("row%0d_tx_n", r), ntx, 1);
      chk($sformatf("row%0d_rx_n", r), nrx, tbl[r].rx_n);
      chk($sformatf("row%0d_strobe_n", r), nsb, 4);
      chk($sformatf("row%0d_strobe_gap", r), badgap, 0);
      chk($sformatf("row%0d_flags", r), {o_start_err, o_overrun}, 2'b00);
      i_enable = 0; auto_ack = 0;
      step(); step();
    end

    // Tx loop never acks: error 8 cycles after the pulse, clear, set-wins.
    do_reset();
    start_run(20, 0, 1'b0);
    run_to(5);  chk("B_tx_pulse", o_tx_start, 1);
    run_to(12); chk("B_err_pre", o_start_err, 0);
    run_to(13); chk("B_err_set", o_start_err, 1);
    i_clr_err = 1;
    run_to(14); chk("B_err_clr", o_start_err, 0);
    i_clr_err = 0; i_rx_en = 1;
    run_to(25); chk("B_rx_pulse", o_rx_start, 1);
    run_to(30); i_clr_err = 1;
    run_to(33); chk("B_set_wins", o_start_err, 1);
    run_to(34); chk("B_clr_after", o_start_err, 0);
    i_clr_err = 0;
    chk("B_no_ov", o_overrun, 0);

    // Rx loop still active across the slot wrap.
    do_reset();
    start_run(20, 0, 1'b1);
    run_to(6);  i_tx_active = 1;
    run_to(11); i_tx_active = 0;
    run_to(26); i_rx_active = 1;
    run_to(40); chk("C_ov_pre", o_overrun, 0);
    run_to(41); chk("C_ov_set", o_overrun, 1);
    chk("C_strobe", {o_slot_strobe, o_slot_idx}, 3'b110);
    run_to(45); chk("C_rx_next", o_rx_start, 1);
    run_to(47); i_rx_active = 0;
    run_to(50); chk("C_flags", {o_start_err, o_overrun}, 2'b01);

    // Enable dropped at slot_cnt 3 of slot 1; sticky error survives.
    do_reset();
    start_run(20, 2, 1'b1);
    run_to(13); chk("D_err", o_start_err, 1);
    run_to(24); chk("D_idx1", o_slot_idx, 1);
    i_enable = 0;
    run_to(25); chk("D_off", dutv(), 8'b0000_0010);
    run_to(30); chk("D_idle", dutv(), 8'b0000_0010);
    auto_ack = 1; i_enable = 1; rel = 0;
    run_to(1); chk("D_restart", {o_slot_strobe, o_busy, o_slot_idx}, 4'b1100);
    run_to(5); chk("D_rx", o_rx_start, 1);

    // One-cycle reset while waiting for the rx ack.
    do_reset();
    start_run(20, 0, 1'b1);
    run_to(13); chk("E_err", o_start_err, 1);
    run_to(27); reset_n = 0; i_enable = 0;
    run_to(28); chk("E_reset", dutv(), 8'h00);
    reset_n = 1;
    run_to(33); chk("E_idle", dutv(), 8'h00);
    i_enable = 1; rel = 0;
    run_to(1); chk("E_restart", {o_slot_strobe, o_busy, o_slot_idx}, 4'b1100);
    run_to(5); chk("E_tx", o_tx_start, 1);

    // Randomized traffic against the model, every cycle.
    for (int s = 0; s < 8; s++) begin
      do_reset();
      i_node_id = 8'($urandom);
      i_rx_en   = 1'($urandom % 2);
      for (int k = 0; k < 250; k++) begin
        i_slot_len  = CW'($urandom_range(0, 30));
        i_tx_active = ($urandom % 3 == 0);
        i_rx_active = ($urandom % 3 == 0);
        i_clr_err   = ($urandom % 16 == 0);
        if (!i_enable) i_enable = ($urandom % 4 == 0);
        else if ($urandom % 120 == 0) i_enable = 0;
        reset_n = ($urandom % 300 != 0);
        step();
        chk("F_model", dutv(), mexp());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/txrx_slot_scheduler.md
Name: txrx_slot_scheduler

Overview:
- TDMA scheduler for the half-duplex VLC link. Time is divided into NUM_SLOTS fixed-length slots per frame.
- It issues one-cycle start pulses to the tx loop in the node's own slot and to the rx loop in every other slot, with a guard interval at the start of each slot.
- It supervises the loops' active handshakes and flags start failures and slot overruns.
- It sits between the top-level sequencer, which drives enable and node id after config load, and the tx/rx loop datapath.

Parameters:
- NUM_SLOTS, 4, slots per frame. Must be a power of 2 and at least 2.
- CNT_W, 32, width of the slot cycle counter and of i_slot_len.
- GUARD_CNT, 2000, idle cycles at the start of each slot before any start pulse.
- ACK_TIMEOUT, 64, cycles allowed between a start pulse and the matching active assertion.

Ports:
- clk  in  1  system clock (20 MHz domain).
- reset_n  in  1  synchronous, active-low reset.
- i_enable  in  1  level; 1 runs the scheduler.
- i_node_id  in  8  node id; own slot = i_node_id[$clog2(NUM_SLOTS)-1:0].
- i_slot_len  in  CNT_W  slot length in clk cycles; latched at enable.
- i_rx_en  in  1  1 = issue rx starts in non-own slots.
- i_tx_active  in  1  tx loop busy.
- i_rx_active  in  1  rx loop busy.
- i_clr_err  in  1  clears the sticky error flags.
- o_tx_start  out  1  one-cycle pulse to the tx loop.
- o_rx_start  out  1  one-cycle pulse to the rx loop.
- o_slot_idx  out  $clog2(NUM_SLOTS)  current slot.
- o_slot_strobe  out  1  one-cycle pulse at slot_cnt==0.
- o_busy  out  1  scheduler not in IDLE.
- o_start_err  out  1  sticky: ack timeout.
- o_overrun  out  1  sticky: active still high at slot end.

Behaviour:
- Reset (reset_n==0 at a clk edge):
  - All outputs = 0.
  - slot_cnt = 0, slot_idx = 0, state = IDLE, latched length = 0.
  - Reset mid-slot aborts immediately; no pulse is emitted in the reset cycle.
- States: IDLE, GUARD, START, WAIT_ACK, RUN.
- IDLE: on i_enable==1, latch len = max(i_slot_len, GUARD_CNT+ACK_TIMEOUT+2).
  - The next cycle has slot_cnt=0, slot_idx=0, o_slot_strobe=1, state=GUARD.
- Slot timing (all non-IDLE states):
  - slot_cnt increments every cycle.
  - When slot_cnt==len-1, slot_cnt wraps to 0 and slot_idx increments modulo NUM_SLOTS (natural wrap).
  - o_slot_strobe=1 in every cycle with slot_cnt==0; state returns to GUARD.
- GUARD: at slot_cnt==GUARD_CNT-1, go to START.
- START (slot_cnt==GUARD_CNT), exactly one pulse per slot:
  - If slot_idx==own slot: o_tx_start=1, go to WAIT_ACK.
  - Else if i_rx_en: o_rx_start=1, go to WAIT_ACK.
  - Else: no pulse, go to RUN.
- WAIT_ACK: waits for the selected active (tx or rx) to go high.
  - If seen within ACK_TIMEOUT cycles after the pulse: go to RUN.
  - Otherwise set o_start_err=1 and go to RUN. No retry in that slot.
- RUN: holds until the slot wraps.
- Slot end: on the wrap cycle, if i_tx_active or i_rx_active is 1, set o_overrun=1. The next slot proceeds normally and the start pulse is still issued.
- Active already high at START: counts as ack on the first WAIT_ACK cycle.
- i_enable falls in any state:
  - Next cycle: state=IDLE, slot_cnt=0, slot_idx=0, no pulses, o_busy=0.
  - Sticky flags are kept.
- i_slot_len and i_node_id changes while running:
  - i_slot_len is ignored until the next enable.
  - i_node_id is sampled at each START.
- i_clr_err clears both sticky flags next cycle. If a set event occurs in the same cycle, set wins.
- o_busy = (state != IDLE).
- Latency: enable rise to first start pulse = GUARD_CNT+1 cycles.

Test Plan:
- Default-reduced params (NUM_SLOTS=4, GUARD_CNT=4, ACK_TIMEOUT=8), i_slot_len=20, node_id=2, i_rx_en=1, loops ack after 2 cycles, enable held for 80 cycles:
  - o_rx_start at cycles 5, 25, 65 after enable rise.
  - o_tx_start at cycle 45.
  - o_slot_strobe every 20 cycles; no errors.
- Same setup, i_slot_len=5:
  - Latched len = 14; strobes every 14 cycles.
- tx loop never asserts active:
  - o_start_err rises 8 cycles after the tx pulse.
  - i_clr_err clears it one cycle later.
- i_rx_active held high past the slot wrap:
  - o_overrun=1 on the cycle after the wrap.
  - Next slot's start pulse is still issued.
- Enable dropped at slot_cnt=3 of slot 1:
  - Next cycle IDLE, o_busy=0, o_slot_idx=0, no pulses.
  - Re-enable restarts at slot 0.
- reset_n low for 1 cycle during WAIT_ACK:
  - All outputs 0 next cycle, including the sticky flags.
  - Scheduler idle until enable.
